// File: rtl/qddc_var.sv
// Quadrature down-converter: tuner (or bypass), per-rail CIC with run-time decimation,
// gain/saturation and a flush-on-reconfigure handshake. Also holds the coarse LO tuner.

module ri_co_tuner #(
    parameter int ISZ = 16,
    parameter int FSZ = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic signed [ISZ-1:0] in,
    input  logic [FSZ-1:0]        lo_freq,
    input  logic                  lo_dir,
    input  logic                  lo_ns_en,
    output logic signed [ISZ-1:0] out_i,
    output logic signed [ISZ-1:0] out_q
);
    localparam logic signed [ISZ-1:0] SMIN = {1'b1, {(ISZ-1){1'b0}}};
    localparam logic signed [ISZ-1:0] SMAX = {1'b0, {(ISZ-1){1'b1}}};

    logic [FSZ-1:0]        phase_q, step, dith;
    logic [7:0]            lfsr_q;
    logic signed [ISZ-1:0] neg_in, mix_i, mix_q, out_i_q, out_q_q;

    // Quarter-wave LO: cos/sin take only the values {1, 0, -1, 0}.
    always_comb begin
        step   = lo_dir ? -lo_freq : lo_freq;
        dith   = lo_ns_en ? FSZ'(lfsr_q) : '0;
        neg_in = (in == SMIN) ? SMAX : -in;
        mix_i  = '0;
        mix_q  = '0;
        case (phase_q[FSZ-1 -: 2])
            2'd0:    mix_i = in;
            2'd1:    mix_q = neg_in;
            2'd2:    mix_i = neg_in;
            default: mix_q = in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            lfsr_q  <= 8'h01;
            out_i_q <= '0;
            out_q_q <= '0;
        end else if (en) begin
            phase_q <= phase_q + step + dith;
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            out_i_q <= mix_i;
            out_q_q <= mix_q;
        end
    end

    assign out_i = out_i_q;
    assign out_q = out_q_q;
endmodule

module qddc_var #(
    parameter int ISZ          = 16,
    parameter int FSZ          = 31,
    parameter int OSZ          = 16,
    parameter int NUM_STAGES   = 4,
    parameter int MAX_LOG2_DEC = 7,
    parameter int MIN_LOG2_DEC = 1,
    parameter int DSZ          = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [ISZ-1:0] in,
    input  logic [FSZ-1:0]        lo_freq,
    input  logic                  lo_dir,
    input  logic                  lo_ns_en,
    input  logic                  tuner_bypass,
    input  logic                  iq_swap,
    input  logic [DSZ-1:0]        dec_log2,
    input  logic [3:0]            gain,
    input  logic                  cfg_load,
    output logic                  cfg_busy,
    output logic signed [OSZ-1:0] out_i,
    output logic signed [OSZ-1:0] out_q,
    output logic                  out_valid,
    output logic                  ovf,
    input  logic                  ovf_clr
);
    localparam int W   = ISZ + NUM_STAGES * MAX_LOG2_DEC;
    localparam int CW  = MAX_LOG2_DEC + 1;
    localparam int XW  = W + 16;
    localparam int SHW = $clog2(W + 1);
    localparam int FCW = $clog2(NUM_STAGES + 1);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StPend  = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    logic [CW-1:0]         cnt_q, rate_mask;
    logic                  in_strobe, out_strobe, load;
    logic [1:0]            state_q;
    logic [DSZ-1:0]        adl_q, pend_q, dec_clamped;
    logic [FCW-1:0]        flush_q;
    logic                  clr_q, reload_q;
    logic signed [ISZ-1:0] tun_i, tun_q;
    logic signed [W-1:0]   rail   [2];
    logic signed [W-1:0]   integ_q[2][NUM_STAGES];
    logic signed [W-1:0]   dly_q  [2][NUM_STAGES];
    logic signed [W-1:0]   cval   [2][NUM_STAGES+1];
    logic signed [W-1:0]   norm   [2];
    logic signed [XW-1:0]  scaled [2];
    logic [OSZ-1:0]        sat    [2];
    logic                  clip   [2];
    logic [SHW-1:0]        nshift;
    logic [OSZ-1:0]        out_i_q, out_q_q;
    logic                  out_valid_q, ovf_q;

    ri_co_tuner #(
        .ISZ(ISZ),
        .FSZ(FSZ)
    ) u_tuner (
        .clk     (clk),
        .reset   (reset),
        .en      (in_strobe),
        .in      (in),
        .lo_freq (lo_freq),
        .lo_dir  (lo_dir),
        .lo_ns_en(lo_ns_en),
        .out_i   (tun_i),
        .out_q   (tun_q)
    );

    always_comb begin
        if (dec_log2 < DSZ'(MIN_LOG2_DEC)) begin
            dec_clamped = DSZ'(MIN_LOG2_DEC);
        end else if (dec_log2 > DSZ'(MAX_LOG2_DEC)) begin
            dec_clamped = DSZ'(MAX_LOG2_DEC);
        end else begin
            dec_clamped = dec_log2;
        end
        rate_mask = '0;
        for (int b = 0; b < CW; b++) begin
            rate_mask[b] = (DSZ'(b) <= adl_q);
        end
    end

    assign in_strobe  = cnt_q[0];
    assign out_strobe = ((cnt_q & rate_mask) == rate_mask);
    assign load       = out_strobe && (state_q != StFlush);
    assign cfg_busy   = (state_q != StRun);

    // Comb chain is combinational so the output register can load on the strobe edge itself.
    always_comb begin
        rail[0] = W'(tuner_bypass ? in : tun_i);
        rail[1] = tuner_bypass ? '0 : W'(tun_q);
        nshift  = SHW'(NUM_STAGES) * SHW'(adl_q);
        for (int r = 0; r < 2; r++) begin
            cval[r][0] = integ_q[r][NUM_STAGES-1];
            for (int k = 0; k < NUM_STAGES; k++) begin
                cval[r][k+1] = cval[r][k] - dly_q[r][k];
            end
            norm[r]   = cval[r][NUM_STAGES] >>> nshift;
            scaled[r] = XW'(norm[r]) <<< gain;
            clip[r]   = !((&scaled[r][XW-1:OSZ-1]) || !(|scaled[r][XW-1:OSZ-1]));
            if (clip[r]) begin
                sat[r] = scaled[r][XW-1] ? {1'b1, {(OSZ-1){1'b0}}} : {1'b0, {(OSZ-1){1'b1}}};
            end else begin
                sat[r] = scaled[r][OSZ-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_q) begin
            cnt_q <= '0;
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    integ_q[r][k] <= '0;
                    dly_q[r][k]   <= '0;
                end
            end
        end else begin
            cnt_q <= cnt_q + CW'(1);
            for (int r = 0; r < 2; r++) begin
                if (in_strobe) begin
                    integ_q[r][0] <= integ_q[r][0] + rail[r];
                    for (int k = 1; k < NUM_STAGES; k++) begin
                        integ_q[r][k] <= integ_q[r][k] + integ_q[r][k-1];
                    end
                end
                if (out_strobe) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        dly_q[r][k] <= cval[r][k];
                    end
                end
            end
        end
    end

    // The strobe that applies a new ratio also schedules the clear for the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            adl_q    <= DSZ'(MAX_LOG2_DEC - 1);
            pend_q   <= DSZ'(MAX_LOG2_DEC - 1);
            flush_q  <= '0;
            clr_q    <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (cfg_load) begin
                        pend_q  <= dec_clamped;
                        state_q <= StPend;
                    end
                end
                StPend: begin
                    if (cfg_load) pend_q <= dec_clamped;
                    if (out_strobe) begin
                        adl_q   <= cfg_load ? dec_clamped : pend_q;
                        clr_q   <= 1'b1;
                        flush_q <= FCW'(NUM_STAGES);
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (cfg_load) begin
                        pend_q   <= dec_clamped;
                        reload_q <= 1'b1;
                    end
                    if (out_strobe) begin
                        flush_q <= flush_q - FCW'(1);
                        if (flush_q == FCW'(1)) begin
                            state_q  <= (reload_q || cfg_load) ? StPend : StRun;
                            reload_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= load;
            if (load) begin
                out_i_q <= iq_swap ? sat[1] : sat[0];
                out_q_q <= iq_swap ? sat[0] : sat[1];
            end
            if (load && (clip[0] || clip[1])) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
endmodule
